// File: rtl/score_keeper.sv
// score_keeper: round-robin BCD award arbiter, digit-serial BCD adder and frame-synchronous score display.
// Optional macro HISCORE_EN adds a high-score register captured on a new-game clear.
module score_keeper #(
  parameter int DIGITS     = 10,
  parameter int NREQ       = 4,
  parameter int PTS_DIGITS = 3
) (
  input  logic                         clk,
  input  logic                         resetN,
  input  logic                         frame_start,
  input  logic                         clear,
  input  logic [NREQ-1:0]              req_valid,
  input  logic [NREQ*4*PTS_DIGITS-1:0] req_points,
  output logic [NREQ-1:0]              req_ready,
  output logic [4*DIGITS-1:0]          digits,
  output logic                         busy,
  output logic                         saturated
`ifdef HISCORE_EN
  ,
  output logic [4*DIGITS-1:0]          hiscore
`endif
);

  localparam int W  = 4 * DIGITS;
  localparam int PW = 4 * PTS_DIGITS;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int LW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [IW-1:0] LAST_IDX  = IW'(DIGITS - 1);
  localparam logic [W-1:0]  ALL_NINES = {DIGITS{4'h9}};

  typedef enum logic {
    IDLE = 1'b0,
    ADD  = 1'b1
  } state_t;

  state_t         state_reg, state_next;
  logic [W-1:0]   work_reg;
  logic [W-1:0]   add_reg;
  logic [W-1:0]   digits_reg;
  logic [IW-1:0]  idx_reg;
  logic           cy_reg;
  logic [LW-1:0]  last_reg;
  logic           pend_reg;
  logic           sat_reg;
`ifdef HISCORE_EN
  logic [W-1:0]   hiscore_reg;
`endif

  logic [LW-1:0]  grant_idx;
  logic           grant_any;
  logic           accept;
  logic [PW-1:0]  pts_sel;
  logic [PW-1:0]  pts_clamp;

  // Later offsets are visited first so the nearest valid requester after last wins.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = last_reg;
    for (int k = NREQ; k >= 1; k--) begin
      for (int i = 0; i < NREQ; i++) begin
        if (i == (int'(last_reg) + k) % NREQ && req_valid[i]) begin
          grant_any = 1'b1;
          grant_idx = LW'(i);
        end
      end
    end
  end

  always_comb begin
    pts_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_idx == LW'(i)) begin
        pts_sel = req_points[i*PW +: PW];
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < PTS_DIGITS; gi++) begin : g_clamp
      assign pts_clamp[gi*4 +: 4] = (pts_sel[gi*4 +: 4] > 4'd9) ? 4'd9 : pts_sel[gi*4 +: 4];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!resetN) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    req_ready  = '0;
    case (state_reg)
      IDLE: begin
        if (resetN && !clear && grant_any) begin
          accept     = 1'b1;
          state_next = ADD;
        end
      end
      ADD: begin
        if (idx_reg == LAST_IDX) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    for (int i = 0; i < NREQ; i++) begin
      req_ready[i] = accept && (grant_idx == LW'(i));
    end
  end

  logic [3:0] work_digit, add_digit, sum_digit;
  logic [4:0] sum, sum_minus_ten;
  logic       carry_out;

  always_comb begin
    work_digit    = work_reg[{idx_reg, 2'b00} +: 4];
    add_digit     = add_reg[{idx_reg, 2'b00} +: 4];
    sum           = {1'b0, work_digit} + {1'b0, add_digit} + {4'b0000, cy_reg};
    sum_minus_ten = sum - 5'd10;
    carry_out     = (sum > 5'd9);
    sum_digit     = carry_out ? sum_minus_ten[3:0] : sum[3:0];
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      work_reg    <= '0;
      add_reg     <= '0;
      digits_reg  <= '0;
      idx_reg     <= '0;
      cy_reg      <= 1'b0;
      last_reg    <= LW'(NREQ - 1);
      pend_reg    <= 1'b0;
      sat_reg     <= 1'b0;
`ifdef HISCORE_EN
      hiscore_reg <= '0;
`endif
    end else if (state_reg == IDLE) begin
      // The copy sees work before any clear or grant on this same edge.
      if (frame_start || pend_reg) begin
        digits_reg <= work_reg;
        pend_reg   <= 1'b0;
      end
      if (clear) begin
        work_reg <= '0;
        sat_reg  <= 1'b0;
`ifdef HISCORE_EN
        if (work_reg > hiscore_reg) begin
          hiscore_reg <= work_reg;
        end
`endif
      end else if (accept) begin
        add_reg  <= W'(pts_clamp);
        last_reg <= grant_idx;
        idx_reg  <= '0;
        cy_reg   <= 1'b0;
      end
    end else begin
      if (frame_start) begin
        pend_reg <= 1'b1;
      end
      if (idx_reg == LAST_IDX) begin
        idx_reg <= '0;
        cy_reg  <= 1'b0;
        if (carry_out) begin
          work_reg <= ALL_NINES;
          sat_reg  <= 1'b1;
        end else begin
          work_reg[{idx_reg, 2'b00} +: 4] <= sum_digit;
        end
      end else begin
        work_reg[{idx_reg, 2'b00} +: 4] <= sum_digit;
        cy_reg  <= carry_out;
        idx_reg <= idx_reg + 1'b1;
      end
    end
  end

  assign digits    = digits_reg;
  assign busy      = (state_reg == ADD);
  assign saturated = sat_reg;
`ifdef HISCORE_EN
  assign hiscore   = hiscore_reg;
`endif

endmodule

// File: tb/tb_score_keeper.sv
// tb_score_keeper: randomized award/frame/clear stimulus, integer score model, queue-based grant and display scoreboard.
module tb_score_keeper;
  localparam int     DIGITS    = 10;
  localparam longint MAX_SCORE = 64'd9999999999;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetN, frame_start, clear;
  logic [3:0]  req_valid, req_ready;
  logic [47:0] req_points;
  logic [39:0] digits;
  logic        busy, saturated;

  logic        s_frame_start, s_clear, s_busy, s_saturated;
  logic [0:0]  s_req_valid, s_req_ready;
  logic [7:0]  s_req_points, s_digits;
`ifdef HISCORE_EN
  logic [39:0] hiscore;
  logic [7:0]  s_hiscore;
`endif

  score_keeper #(.DIGITS(10), .NREQ(4), .PTS_DIGITS(3)) dut (
    .clk(clk),
`ifdef HISCORE_EN
    .hiscore(hiscore),
`endif
    .resetN(resetN), .frame_start(frame_start), .clear(clear),
    .req_valid(req_valid), .req_points(req_points), .req_ready(req_ready),
    .digits(digits), .busy(busy), .saturated(saturated)
  );

  score_keeper #(.DIGITS(2), .NREQ(1), .PTS_DIGITS(2)) dut_small (
    .clk(clk),
`ifdef HISCORE_EN
    .hiscore(s_hiscore),
`endif
    .resetN(resetN), .frame_start(s_frame_start), .clear(s_clear),
    .req_valid(s_req_valid), .req_points(s_req_points), .req_ready(s_req_ready),
    .digits(s_digits), .busy(s_busy), .saturated(s_saturated)
  );

  int vectors = 0;
  int miscompares = 0;

  logic [3:0]  grant_q[$];
  logic [39:0] disp_q[$];

  longint      score_m, hi_m;
  logic        sat_m;
  logic [3:0]  pend_m;
  logic [11:0] pts_m[4];
  int          last_m;
  logic        copy_pending_tb;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic longint pts_val(input logic [11:0] p);
    longint v = 0;
    longint m = 1;
    logic [3:0] n;
    for (int d = 0; d < 3; d++) begin
      n = p[d*4 +: 4];
      if (n > 4'd9) n = 4'd9;
      v += longint'(n) * m;
      m *= 10;
    end
    return v;
  endfunction

  function automatic logic [39:0] to_bcd(input longint v);
    logic [39:0] r;
    for (int i = 0; i < DIGITS; i++) begin
      r[i*4 +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  task automatic drive_reqs();
    req_valid = pend_m;
    for (int i = 0; i < 4; i++) req_points[i*12 +: 12] = pts_m[i];
  endtask

  task automatic add_req(input int i, input logic [11:0] p);
    pend_m[i] = 1'b1;
    pts_m[i]  = p;
  endtask

  // Monitor: grant handshakes, display copies, digit stability, ADD length.
  initial begin : monitor
    logic        copy_due, mpend;
    logic [39:0] shown;
    int          busy_run;
    copy_due = 1'b0; mpend = 1'b0; shown = '0; busy_run = 0;
    forever begin
      @(negedge clk);
      if (!resetN) begin
        copy_due = 1'b0; mpend = 1'b0; shown = '0; busy_run = 0;
      end else begin
        if (copy_due) begin
          if (disp_q.size() == 0) begin
            vectors++; miscompares++;
            $display("FAIL display_copy: digits copied to %0h, required no copy", digits);
          end else begin
            shown = disp_q.pop_front();
            check("digits", digits, shown);
          end
        end else begin
          check("digits_stable", digits, shown);
        end
        if (|(req_valid & req_ready)) begin
          if (grant_q.size() == 0) begin
            vectors++; miscompares++;
            $display("FAIL grant: got unexpected req_ready %b, required none", req_ready);
          end else begin
            check("grant", req_ready, grant_q.pop_front());
          end
        end
        if (busy) begin
          busy_run++;
          check("ready_in_add", req_ready, 0);
        end else if (busy_run != 0) begin
          check("busy_len", busy_run, DIGITS);
          busy_run = 0;
        end
        copy_due = !busy && (frame_start || mpend);
        if (copy_due) mpend = 1'b0;
        else if (busy && frame_start) mpend = 1'b1;
      end
    end
  end

  // fs_at: -1 none, -2 frame on the grant edge, 0..DIGITS-1 frame at that ADD digit.
  task automatic award(input int fs_at);
    int g, n;
    g = -1;
    for (int k = 1; k <= 4; k++) begin
      if (g < 0 && pend_m[2'((last_m + k) % 4)]) g = (last_m + k) % 4;
    end
    drive_reqs();
    grant_q.push_back(4'(1 << g));
    #1;
    n = 0;
    while (!(|(req_valid & req_ready)) && n < 20) begin
      step(); n++;
    end
    if (n >= 20) begin
      vectors++; miscompares++;
      $display("FAIL grant_timeout: got no grant, required requester %0d", g);
      void'(grant_q.pop_back());
      return;
    end
    if (fs_at == -2) begin
      frame_start = 1'b1;
      if (!copy_pending_tb) disp_q.push_back(to_bcd(score_m));
    end
    step();
    frame_start = 1'b0;
    copy_pending_tb = 1'b0;
    score_m = score_m + pts_val(pts_m[g]);
    if (score_m > MAX_SCORE) begin
      score_m = MAX_SCORE;
      sat_m   = 1'b1;
    end
    pend_m[g] = 1'b0;
    last_m    = g;
    drive_reqs();
    for (int i = 0; i < DIGITS; i++) begin
      if (i == fs_at) begin
        frame_start = 1'b1;
        disp_q.push_back(to_bcd(score_m));
      end
      step();
      frame_start = 1'b0;
    end
    if (fs_at >= 0) copy_pending_tb = 1'b1;
  endtask

  task automatic frame();
    frame_start = 1'b1;
    if (!copy_pending_tb) disp_q.push_back(to_bcd(score_m));
    check("saturated", saturated, sat_m);
    step();
    frame_start = 1'b0;
    copy_pending_tb = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      step();
      copy_pending_tb = 1'b0;
    end
  endtask

  task automatic do_clear();
    clear = 1'b1;
    drive_reqs();
    #1;
    check("ready_on_clear", req_ready, 0);
    if (score_m > hi_m) hi_m = score_m;
    score_m = 0;
    sat_m   = 1'b0;
    step();
    clear = 1'b0;
    copy_pending_tb = 1'b0;
    check("saturated_clear", saturated, 0);
`ifdef HISCORE_EN
    check("hiscore", hiscore, to_bcd(hi_m));
`endif
  endtask

  task automatic do_reset();
    idle(2);
    check("disp_q_drained", disp_q.size(), 0);
    check("grant_q_drained", grant_q.size(), 0);
    resetN = 1'b0; clear = 1'b0; frame_start = 1'b0;
    req_valid = 4'hF; req_points = '0;
    s_req_valid = 1'b1; s_frame_start = 1'b0; s_clear = 1'b0;
    repeat (3) step();
    check("ready_in_reset", req_ready, 0);
    check("s_ready_in_reset", s_req_ready, 0);
    req_valid = '0; s_req_valid = 1'b0;
    resetN = 1'b1;
    pend_m = '0; score_m = 0; hi_m = 0; sat_m = 1'b0; last_m = 3;
    for (int i = 0; i < 4; i++) pts_m[i] = '0;
    check("digits_reset", digits, 0);
    check("busy_reset", busy, 0);
    check("saturated_reset", saturated, 0);
`ifdef HISCORE_EN
    check("hiscore_reset", hiscore, 0);
`endif
  endtask

  task automatic s_award(input logic [7:0] p);
    int n;
    s_req_points = p;
    s_req_valid  = 1'b1;
    #1;
    n = 0;
    while (!s_req_ready[0] && n < 20) begin
      step(); n++;
    end
    check("s_handshake", s_req_ready, 1);
    step();
    s_req_valid = 1'b0;
    n = 0;
    while (s_busy && n < 20) begin
      step(); n++;
    end
    check("s_busy_done", s_busy, 0);
  endtask

  task automatic s_frame();
    s_frame_start = 1'b1;
    step();
    s_frame_start = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    resetN = 1'b0; frame_start = 1'b0; clear = 1'b0;
    req_valid = '0; req_points = '0;
    s_frame_start = 1'b0; s_clear = 1'b0; s_req_valid = '0; s_req_points = '0;
    copy_pending_tb = 1'b0; pend_m = '0;
    do_reset();

    // All four held with points 1..4: grants 0,1,2,3 then 0 again.
    for (int i = 0; i < 4; i++) add_req(i, 12'(i + 1));
    repeat (4) award(-1);
    frame();
    add_req(0, 12'h001);
    award(-1);
    frame();

    do_reset();
    add_req(0, 12'h150);
    award(-1);
    frame();

    // Carry ripple 999 + 1.
    do_clear();
    add_req(0, 12'h999);
    award(-1);
    add_req(0, 12'h001);
    award(-1);
    frame();

    // Frame mid-ADD, then frame on the grant edge, then clear racing a request.
    add_req(2, 12'h234);
    award(3);
    idle(5);
    add_req(1, 12'h077);
    award(-2);
    frame();
    add_req(1, 12'h555);
    do_clear();
    award(-2);
    frame();

    for (int it = 0; it < 150; it++) begin
      for (int i = 0; i < 4; i++) begin
        if (!pend_m[i] && $urandom_range(0, 2) == 0) add_req(i, 12'($urandom));
      end
      if ($urandom_range(0, 19) == 0) do_clear();
      if (pend_m != 0) award(int'($urandom_range(0, DIGITS + 1)) - 2);
      else if ($urandom_range(0, 1) == 0) frame();
      else idle(int'($urandom_range(1, 3)));
    end
    while (pend_m != 0) award(-1);
    frame();
    idle(3);
    check("disp_q_empty", disp_q.size(), 0);
    check("grant_q_empty", grant_q.size(), 0);

    // Two-digit instance saturation.
    s_award(8'h99);
    s_award(8'h01);
    s_frame();
    check("s_digits_sat", s_digits, 8'h99);
    check("s_saturated", s_saturated, 1);
    s_award(8'h05);
    s_frame();
    check("s_digits_hold", s_digits, 8'h99);
    check("s_saturated_hold", s_saturated, 1);

    idle(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/score_keeper.md
Name: score_keeper

Overview:
- Owns the game score and feeds the `digits` vector of Draw_Score.
- Accepts BCD point-award requests from several sources (asteroid hits, UFO hits, bonuses) through valid/ready and picks between them round-robin.
- Adds each award with a digit-serial BCD adder, one digit per clock.
- Publishes the displayed score only on frame boundaries, so the score never tears mid-frame.

Parameters:
- DIGITS, 10, number of BCD digits in the score. Must match Draw_Score.DIGITS.
- NREQ, 4, number of award requesters (1..8).
- PTS_DIGITS, 3, BCD digits per award (1..DIGITS).

Ports:
- clk  in  1  pixel/system clock.
- resetN  in  1  synchronous, active-low reset.
- frame_start  in  1  one-cycle pulse at start of vertical blank.
- clear  in  1  synchronous new-game clear of the score.
- req_valid  in  NREQ  per-requester award valid. The requester holds it until accepted.
- req_points  in  NREQ*4*PTS_DIGITS  packed BCD awards. Requester i uses slice [i*4*PTS_DIGITS +: 4*PTS_DIGITS].
- req_ready  out  NREQ  one-hot grant, combinational. A transfer occurs when req_valid[i] && req_ready[i].
- digits  out  4*DIGITS  displayed score, BCD, digit 0 = LSD at [3:0]. Connects to Draw_Score.digits.
- busy  out  1  high while in ADD.
- saturated  out  1  sticky flag: score has clamped at all-9s.

Behaviour:
- Internal state:
  - working score `work` (4*DIGITS).
  - latched addend `add_r` (4*DIGITS, upper digits zero).
  - digit index `idx`, carry bit `cy`.
  - round-robin pointer `last`, display-pending flag `pend`.
- Reset (resetN=0 at a clk edge):
  - state=IDLE; work=0, digits=0, add_r=0, idx=0, cy=0, pend=0.
  - saturated=0, busy=0, last=NREQ-1, so requester 0 wins first.
  - req_ready is forced to 0 while resetN=0.
- FSM with two states, IDLE and ADD.
- IDLE:
  - If clear=1: work<=0, saturated<=0, req_ready=0, stay IDLE.
  - Else if any req_valid: grant the first valid index searching from last+1 upward, wrapping mod NREQ.
    - req_ready[g]=1 that cycle only.
    - On the edge: add_r<=req_points slice of g, with any BCD digit >9 clamped to 9.
    - last<=g, idx<=0, cy<=0, state<=ADD.
- ADD:
  - Each cycle: s = work[idx]+add_r[idx]+cy, a 5-bit sum.
  - If s>9: work[idx]<=s-10, cy<=1. Else work[idx]<=s, cy<=0.
  - idx increments each cycle.
  - At idx==DIGITS-1 with carry-out=1: work<=all 9s, saturated<=1.
  - At idx==DIGITS-1, state<=IDLE regardless of carry.
  - ADD lasts exactly DIGITS cycles. busy=1 during ADD. req_ready=0 during ADD.
  - clear during ADD is ignored. The requester must hold clear until busy=0; the game FSM guarantees this.
- Accept rate: at most one award per DIGITS+1 cycles.
- Display update:
  - On an edge where state==IDLE and (frame_start || pend): digits<=work using its value before that edge, and pend<=0.
  - frame_start while in ADD sets pend<=1. The copy then occurs on the first IDLE cycle after ADD, which is still inside vertical blank.
  - A grant or clear on the same edge as the copy does not affect the copied value.
  - No frame_start means digits is never updated.
- Saturation: once saturated, further awards are still accepted (handshake completes, ADD runs DIGITS cycles) and the score stays all 9s.

Optional Feature:
- Macro HISCORE_EN.
- Defined:
  - Adds output port `hiscore` (4*DIGITS), reset to 0.
  - On an IDLE-state clear, if work > hiscore, then hiscore<=work. This is an unsigned compare of the packed BCD vectors, which preserves order. The update happens on the same edge as work<=0.
- Undefined: the port and register are absent; all other behaviour is identical.

Test Plan:
- Reset, then req_valid[0]=1 with points 12'h150.
  - Required: req_ready[0] high 1 cycle, busy high 10 cycles.
  - Then frame_start gives digits=40'h0000000150.
- Score 40'h0000000999 plus award 12'h001 → digits=40'h0000001000 after the next frame_start; carry ripples through 3 digits.
- All four req_valid held high, points 1/2/3/4.
  - Required grant order 0,1,2,3,0.
  - After 4 adds and a frame_start, digits=40'h0000000010.
- DIGITS=2, PTS_DIGITS=2 instance: add 8'h99, then 8'h01.
  - Required: digits=8'h99 and saturated=1.
  - A further 8'h05 award still handshakes; the score stays 8'h99.
- frame_start pulsed at idx=3 of an ADD.
  - Required: digits unchanged during ADD, new sum on the cycle after ADD ends, and no further change without another frame_start.
- clear and req_valid[1] asserted together in IDLE.
  - Required: req_ready=0, work=0, saturated=0, digits=0 after the next frame_start.
  - With HISCORE_EN: hiscore takes the prior score if it was higher.
